fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write port of the 32-bit fifo between NUM_REQ producers, round-robin.
//  Tracks fifo occupancy locally, so a registered write is never issued into a full fifo.
//  Sits directly in front of the fifo write_request/write_data pins.
//  Shares clk, clk_en and rst with the fifo.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  32  fifo word width
//  FIFO_DEPTH  16  fifo capacity in words; must match the fifo instance
//  LVL_W       $clog2(FIFO_DEPTH+1)  width of the level counter
// PORTS
//  clk            in   1                   system clock, rising edge
//  rst            in   1                   synchronous, active-high reset
//  clk_en         in   1                   global clock enable (same signal as the fifo's)
//  req            in   NUM_REQ             per-requester write request, held until granted
//  req_data       in   NUM_REQ*DATA_WIDTH  packed data; slice i belongs to req[i]
//  grant          out  NUM_REQ             one-hot, combinational; transfer = req[i]&grant[i]&clk_en at edge
//  write_request  out  1                   registered, drives fifo write_request
//  write_data     out  DATA_WIDTH          registered, drives fifo write_data
//  full           in   1                   fifo full flag
//  empty          in   1                   fifo empty flag
//  read_request   in   1                   consumer's fifo read_request, monitored only
//  level          out  LVL_W               registered count of words committed to the fifo
// BEHAVIOUR
//  Reset: write_request=0, write_data=0, level=0, rr pointer last=NUM_REQ-1 (req 0 wins first).
//  space = (level < FIFO_DEPTH) && !full. full is conservative only; level is authoritative.
//  Grant (combinational):
//   - Set only when clk_en && space && |req.
//   - Winner is the first set req[i] scanning from last+1 with wrap to 0; exactly one bit is set.
//   - grant=0 during rst and while clk_en=0.
//  Enabled edge (clk_en=1, rst=0):
//   - On a transfer to requester i: write_request<=1, write_data<=slice i, last<=i.
//   - With no transfer: write_request<=0 and write_data holds its value.
//   - Latency: req accepted at edge N; the fifo writes the word at edge N+1.
//   - Max throughput: one word per enabled cycle.
//  level:
//   - next = level + wr_issue - rd_seen.
//   - wr_issue = a transfer at this edge (the word is counted when granted, not when written).
//   - rd_seen = read_request && !empty.
//   - Read and write on the same edge: level unchanged.
//   - rd_seen at level 0 is ignored; level never exceeds FIFO_DEPTH (bench asserts both).
//  clk_en=0: all registers hold. A held write_request=1 is consumed by the fifo on its next
//   enabled edge, and the arbiter deasserts it on that same edge.
//  Reset mid-operation:
//   - Pending requests are not granted.
//   - An in-flight write_request is cleared and level returns to 0.
//   - The fifo must reset on the same rst.
//  Fairness: a continuously asserted req waits at most NUM_REQ-1 grants.
// STRUCTURE
//  Shared package fifo_pkg:
//   - DATA_WIDTH and FIFO_DEPTH defaults.
//   - clog2 function.
//   - req_idx_t typedef (index width for NUM_REQ).
//  Sub-module rr_priority_picker:
//   - Pure combinational.
//   - Inputs req vector and last index; outputs one-hot grant and binary idx.
//   - Reusable by a future read-side scheduler.
//  Top level holds: rr pointer, level counter, output register.
// TESTING (bench instantiates the real fifo as the downstream consumer)
//  1 rst=1 for 5 cycles -> write_request=0, write_data=0, level=0, grant=0 even with req=4'b1111.
//  2 req=1111, data i=0x10+i, no reads -> grants 0,1,2,3,0,... one per cycle.
//    The fifo receives 0x10,0x11,0x12,0x13,0x10...
//  3 Continue case 2 -> exactly 16 writes, then grant=0 with level=16.
//    No write_request is seen while full=1.
//  4 At level=16, pulse one read -> level=15 and one grant. Then read and grant on the same edge
//    -> level stays 15 and the data order is preserved.
//  5 Drop clk_en for 3 cycles mid-stream -> grant=0 and level/write_data frozen.
//    The word pending before the stall is written exactly once.
//  6 Assert rst while req=0011 and write_request=1 -> next cycle level=0 and write_request=0.
//    After release, req 0 is granted first.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared fifo defaults, clog2 helper and requester index type
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_NUM_REQ = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction
  typedef logic [clog2(DEF_NUM_REQ)-1:0] req_idx_t;
endpackage

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// rr_priority_picker: one-hot pick of the first set request after the last winner, with wrap
module rr_priority_picker import fifo_pkg::*; #(
  parameter int N = DEF_NUM_REQ,
  parameter int IW = clog2(DEF_NUM_REQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      if (req[j]) begin
        grant = N'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of the fifo write port with local occupancy tracking
module fifo_write_arbiter import fifo_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LVL_W = clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          write_request,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          full,
  input  logic                          empty,
  input  logic                          read_request,
  output logic [LVL_W-1:0]              level
);
  localparam int IW = clog2(NUM_REQ);
  logic [IW-1:0] last, idx;
  logic [NUM_REQ-1:0] pick;
  logic space, xfer, rd_seen;
  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req),
    .last(last),
    .grant(pick),
    .idx(idx)
  );
  always_comb begin
    space = (level < LVL_W'(FIFO_DEPTH)) && !full;
    grant = (clk_en && space && !rst) ? pick : '0;
    xfer = |grant;
    rd_seen = read_request && !empty && (level != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      write_request <= 1'b0;
      write_data <= '0;
      level <= '0;
      last <= IW'(NUM_REQ - 1);
    end else if (clk_en) begin
      write_request <= xfer;
      if (xfer) begin
        write_data <= req_data[idx*DATA_WIDTH +: DATA_WIDTH];
        last <= idx;
      end
      level <= level + LVL_W'(xfer) - LVL_W'(rd_seen);
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scoreboard bench with a behavioural 16-word fifo downstream
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic rst, clk_en, read_request;
  logic [3:0] req, grant;
  logic [127:0] req_data;
  logic write_request;
  logic [31:0] write_data;
  logic [4:0] level;
  logic [31:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  logic f_full, f_empty;
  int wr_count = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  always #5 clk = ~clk;
  assign f_full = (cnt == 5'd16);
  assign f_empty = (cnt == 5'd0);
  fifo_write_arbiter dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .write_request(write_request),
    .write_data(write_data),
    .full(f_full),
    .empty(f_empty),
    .read_request(read_request),
    .level(level)
  );
  always @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clk_en) begin
      if (write_request && !f_full) begin
        mem[wp] <= write_data;
        wp <= wp + 4'd1;
        wr_count <= wr_count + 1;
      end
      if (read_request && !f_empty) rp <= rp + 4'd1;
      cnt <= cnt + 5'(write_request && !f_full) - 5'(read_request && !f_empty);
    end
  end
  always @(negedge clk) begin
    checks++;
    if (level > 5'd16) begin
      errors++;
      $display("FAIL level_bound got=%0d max=16", level);
    end
    if (write_request && clk_en && !rst) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_data unexpected write got=%0h", write_data);
      end else begin
        logic [31:0] e;
        e = wq.pop_front();
        if (write_data !== e || f_full) begin
          errors++;
          $display("FAIL write_data got=%0h exp=%0h full=%0b", write_data, e, f_full);
        end
      end
    end
    if (read_request && clk_en && !rst && !f_empty) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL read_data unexpected read got=%0h", mem[rp]);
      end else begin
        logic [31:0] e;
        e = rq.pop_front();
        if (mem[rp] !== e) begin
          errors++;
          $display("FAIL read_data got=%0h exp=%0h", mem[rp], e);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic drv();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    read_request = 1'b0;
    req = 4'b1111;
    req_data = {32'h13, 32'h12, 32'h11, 32'h10};
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_write_request", 32'(write_request), 32'h0);
    chk("rst_write_data", write_data, 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    drv();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
      wq.push_back(32'h10 + 32'(k % 4));
      drv();
    end
    @(negedge clk);
    chk("full_grant", 32'(grant), 32'h0);
    chk("full_level", 32'(level), 32'd16);
    drv();
    drv();
    @(negedge clk);
    chk("full_writes", 32'(wr_count), 32'd16);
    chk("full_write_request", 32'(write_request), 32'h0);
    chk("full_grant_hold", 32'(grant), 32'h0);
    drv();
    read_request = 1'b1;
    rq.push_back(32'h10);
    @(negedge clk);
    chk("read_grant_wait", 32'(grant), 32'h0);
    drv();
    read_request = 1'b0;
    @(negedge clk);
    chk("read_level", 32'(level), 32'd15);
    chk("read_grant", 32'(grant), 32'b0001);
    wq.push_back(32'h10);
    drv();
    @(negedge clk);
    chk("refill_level", 32'(level), 32'd16);
    drv();
    read_request = 1'b1;
    rq.push_back(32'h11);
    drv();
    rq.push_back(32'h12);
    @(negedge clk);
    chk("same_edge_grant", 32'(grant), 32'b0010);
    chk("same_edge_level_before", 32'(level), 32'd15);
    wq.push_back(32'h11);
    drv();
    read_request = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    chk("same_edge_level", 32'(level), 32'd15);
    drv();
    req = 4'b1111;
    read_request = 1'b1;
    rq.push_back(32'h13);
    @(negedge clk);
    chk("pre_stall_grant", 32'(grant), 32'b0100);
    wq.push_back(32'h12);
    drv();
    read_request = 1'b0;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_grant", 32'(grant), 32'h0);
      chk("stall_level", 32'(level), 32'd15);
      chk("stall_write_data", write_data, 32'h12);
      chk("stall_write_request", 32'(write_request), 32'h1);
      drv();
    end
    clk_en = 1'b1;
    req = 4'b0000;
    drv();
    @(negedge clk);
    chk("post_stall_write_request", 32'(write_request), 32'h0);
    chk("post_stall_writes", 32'(wr_count), 32'd19);
    chk("post_stall_level", 32'(level), 32'd15);
    drv();
    req = 4'b0011;
    @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'b0001);
    drv();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_inflight", 32'(write_request), 32'h1);
    drv();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_level", 32'(level), 32'h0);
    chk("post_rst_write_request", 32'(write_request), 32'h0);
    chk("post_rst_grant", 32'(grant), 32'b0001);
    wq.push_back(32'h10);
    drv();
    req = 4'b0000;
    drv();
    drv();
    @(negedge clk);
    chk("final_writes", 32'(wr_count), 32'd20);
    chk("final_level", 32'(level), 32'd1);
    chk("wq_drained", 32'(wq.size()), 32'h0);
    chk("rq_drained", 32'(rq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
